// File: rtl/scan_clock_ctrl_pkg.sv
// rtl/scan_clock_ctrl_pkg.sv - command codes, FSM states and helpers shared by the scan clock controller
package scan_clock_ctrl_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_SHIFT = 2'd1,
    CMD_EXEC  = 2'd2,
    CMD_FREE  = 2'd3
  } cmd_e;

  typedef enum logic [3:0] {
    IDLE, S_GET, S_LOW, S_HIGH, S_PUT, E_LOW, E_HIGH, F_LOW, F_HIGH, DONE
  } state_e;

  function automatic logic is_high_phase(state_e s);
    return (s == S_HIGH) || (s == E_HIGH) || (s == F_HIGH);
  endfunction

  // se/tm stay asserted across the stream waits, not only while clocking
  function automatic logic is_shift_state(state_e s);
    return (s == S_GET) || (s == S_LOW) || (s == S_HIGH) || (s == S_PUT);
  endfunction

endpackage

// File: rtl/scan_clock_ctrl_if.sv
// rtl/scan_clock_ctrl_if.sv - command, scan-in and scan-out handshakes between command processor and clock controller
interface scan_clock_ctrl_if #(
  parameter int CNT_W = scan_clock_ctrl_pkg::CNT_W_DEF
);
  logic [1:0]       cmd_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [CNT_W-1:0] count_i;
  logic             pause_i;
  logic             sin_valid_i;
  logic             sin_bit_i;
  logic             sin_ready_o;
  logic             sout_valid_o;
  logic             sout_bit_o;
  logic             sout_ready_i;

  modport master (
    output cmd_i, cmd_valid_i, count_i, pause_i, sin_valid_i, sin_bit_i, sout_ready_i,
    input  cmd_ready_o, sin_ready_o, sout_valid_o, sout_bit_o
  );

  modport slave (
    input  cmd_i, cmd_valid_i, count_i, pause_i, sin_valid_i, sin_bit_i, sout_ready_i,
    output cmd_ready_o, sin_ready_o, sout_valid_o, sout_bit_o
  );
endinterface

// File: rtl/scan_clock_ctrl_clk_phase_timer.sv
// rtl/scan_clock_ctrl_clk_phase_timer.sv - CLK_DIV-cycle phase timer, reloaded on every phase entry
module scan_clock_ctrl_clk_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last_o
);
  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last_o = (cnt == '0);
endmodule

// File: rtl/scan_clock_ctrl.sv
// rtl/scan_clock_ctrl.sv - counted DUT clock generator for scan shift, execute and free-run operations
module scan_clock_ctrl
  import scan_clock_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  scan_clock_ctrl_if.slave bus,
  output logic             dut_clk_o,
  output logic             dut_se_o,
  output logic             dut_tm_o,
  output logic             dut_sin_o,
  input  logic             dut_sout_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycles_o
);
  state_e           state, state_n;
  cmd_e             cmd;
  logic             load;
  logic             last;
  logic [CNT_W-1:0] remaining;
  logic             sout_bit_q;

  assign cmd = cmd_e'(bus.cmd_i);

  scan_clock_ctrl_clk_phase_timer #(.CLK_DIV(CLK_DIV)) clk_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .last_o (last)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          case (cmd)
            CMD_NOP:   state_n = DONE;
            CMD_SHIFT: state_n = (bus.count_i == '0) ? DONE : S_GET;
            CMD_EXEC:  state_n = (bus.count_i == '0) ? DONE : E_LOW;
            CMD_FREE:  state_n = F_LOW;
          endcase
        end
      end
      S_GET:  if (bus.sin_valid_i) state_n = S_LOW;
      S_LOW:  if (last) state_n = S_HIGH;
      S_HIGH: if (last) state_n = S_PUT;
      S_PUT:  if (bus.sout_ready_i) state_n = (remaining == CNT_W'(1)) ? DONE : S_GET;
      E_LOW:  if (last) state_n = E_HIGH;
      E_HIGH: if (last) state_n = (remaining == CNT_W'(1)) ? DONE : E_LOW;
      F_LOW:  if (last) state_n = F_HIGH;
      // pause only takes effect once a full high phase has been driven
      F_HIGH: if (last) state_n = bus.pause_i ? DONE : F_LOW;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign load = (state_n != state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      cycles_o   <= '0;
      dut_clk_o  <= 1'b0;
      dut_se_o   <= 1'b0;
      dut_tm_o   <= 1'b0;
      dut_sin_o  <= 1'b0;
      sout_bit_q <= 1'b0;
    end else begin
      state     <= state_n;
      dut_clk_o <= is_high_phase(state_n);
      dut_se_o  <= is_shift_state(state_n);
      dut_tm_o  <= is_shift_state(state_n);

      if (state == IDLE && bus.cmd_valid_i) begin
        remaining <= bus.count_i;
        cycles_o  <= '0;
      end
      if (is_high_phase(state_n) && !is_high_phase(state) && cycles_o != '1) begin
        cycles_o <= cycles_o + CNT_W'(1);
      end

      if (state == S_GET && bus.sin_valid_i) begin
        dut_sin_o <= bus.sin_bit_i;
      end
      // capture scan-out just before the rising edge shifts the chain
      if (state == S_LOW && last) begin
        sout_bit_q <= dut_sout_i;
      end
      if ((state == S_PUT && bus.sout_ready_i) || (state == E_HIGH && last)) begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  assign bus.cmd_ready_o  = (state == IDLE);
  assign bus.sin_ready_o  = (state == S_GET) && bus.sin_valid_i;
  assign bus.sout_valid_o = (state == S_PUT);
  assign bus.sout_bit_o   = sout_bit_q;
  assign busy_o           = (state != IDLE);
  assign done_o           = (state == DONE);
endmodule

// File: tb/tb_scan_clock_ctrl.sv
// tb/tb_scan_clock_ctrl.sv - self-checking bench for scan_clock_ctrl with a 4-bit scan chain model
module tb_scan_clock_ctrl;
  import scan_clock_ctrl_pkg::*;

  localparam int D  = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_clock_ctrl_if #(.CNT_W(CW)) bus ();

  logic          dut_clk, dut_se, dut_tm, dut_sin, dut_sout, busy, done;
  logic [CW-1:0] cycles;

  scan_clock_ctrl #(.CLK_DIV(D), .CNT_W(CW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dut_clk_o  (dut_clk),
    .dut_se_o   (dut_se),
    .dut_tm_o   (dut_tm),
    .dut_sin_o  (dut_sin),
    .dut_sout_i (dut_sout),
    .busy_o     (busy),
    .done_o     (done),
    .cycles_o   (cycles)
  );

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  // scan chain model and DUT clock statistics
  logic [3:0] sreg = 4'b0;
  logic [3:0] preload_val = 4'b0;
  logic       preload_req = 1'b0;
  logic       stat_clr = 1'b0;
  logic       prev_clk = 1'b0;
  int edges = 0, hi_min = 1000, hi_max = 0, lo_min = 1000, run_len = 0;

  assign dut_sout = sreg[3];

  always @(negedge clk) begin
    if (preload_req) sreg <= preload_val;
    else if (!prev_clk && dut_clk) sreg <= {sreg[2:0], dut_sin};
    if (stat_clr) begin
      edges <= 0; hi_min <= 1000; hi_max <= 0; lo_min <= 1000; run_len <= 1;
    end else if (dut_clk != prev_clk) begin
      if (prev_clk) begin
        if (run_len < hi_min) hi_min <= run_len;
        if (run_len > hi_max) hi_max <= run_len;
      end else begin
        edges <= edges + 1;
        if (run_len < lo_min) lo_min <= run_len;
      end
      run_len <= 1;
    end else begin
      run_len <= run_len + 1;
    end
    prev_clk <= dut_clk;
  end

  task automatic clear_stats();
    stat_clr = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    stat_clr = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] c, input int n);
    @(posedge clk); #1;
    bus.cmd_i = c; bus.count_i = CW'(n); bus.cmd_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input logic exp_se, output int lat, output int viol);
    bit found = 0;
    lat = 2; viol = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done) begin found = 1; break; end
      if (busy && (dut_se !== exp_se || dut_tm !== exp_se)) viol++;
      @(posedge clk); #1;
      lat++;
    end
    if (!found) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic run_shift(input int n, input logic [7:0] bits, input logic [3:0] pre,
                           input int stall, output int lat, output int viol, output int stall_hi);
    logic [3:0] m = pre;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m[3]);
      m = {m[2:0], bits[i]};
    end
    stall_hi = 0;
    preload_val = pre; preload_req = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    preload_req = 1'b0;
    clear_stats();
    bus.sout_ready_i = (stall == 0);
    send_cmd(CMD_SHIFT, n);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          bit got = 0;
          bus.sin_bit_i = bits[i]; bus.sin_valid_i = 1'b1;
          for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.sin_ready_o) begin got = 1; break; end
          end
          checks++;
          if (!got) begin errors++; $display("FAIL sin_accept bit %0d got no ready want ready", i); end
          @(posedge clk); #1;
        end
        bus.sin_valid_i = 1'b0;
      end
      begin
        for (int i = 0; i < n; i++) begin
          bit got = 0;
          logic e;
          for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.sout_valid_o) begin got = 1; break; end
          end
          if (got && i == 0 && stall > 0) begin
            repeat (stall) begin
              @(negedge clk);
              if (dut_clk !== 1'b0) stall_hi++;
            end
            bus.sout_ready_i = 1'b1;
          end
          checks++;
          if (!got || exp_q.size() == 0) begin
            errors++; $display("FAIL sout_bit %0d got no data want data", i);
          end else begin
            e = exp_q.pop_front();
            if (bus.sout_bit_o !== e) begin
              errors++; $display("FAIL sout_bit %0d got %b want %b", i, bus.sout_bit_o, e);
            end
          end
          @(posedge clk); #1;
        end
      end
      wait_done(1'b1, lat, viol);
    join
    bus.sout_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {dut_clk, dut_se, dut_tm, dut_sin, bus.sout_valid_o, bus.sout_bit_o,
           bus.sin_ready_o, done, busy, bus.cmd_ready_o};
    checks++;
    if (obs !== 10'b0000000001) begin errors++; $display("FAIL reset_outputs got %b want %b", obs, 10'b0000000001); end
    checks++;
    if (cycles !== '0) begin errors++; $display("FAIL reset_cycles got %0d want 0", cycles); end
    rst = 1'b0;
  endtask

  task automatic test_exec();
    int lat, viol;
    clear_stats();
    bus.pause_i = 1'b1;
    send_cmd(CMD_EXEC, 3);
    wait_done(1'b0, lat, viol);
    bus.pause_i = 1'b0;
    checks++;
    if (lat != 3 * 2 * D + 2) begin errors++; $display("FAIL exec3_latency got %0d want %0d", lat, 3 * 2 * D + 2); end
    checks++;
    if (edges != 3) begin errors++; $display("FAIL exec3_edges got %0d want 3", edges); end
    checks++;
    if (cycles !== CW'(3)) begin errors++; $display("FAIL exec3_cycles got %0d want 3", cycles); end
    checks++;
    if (hi_min != D || hi_max != D) begin errors++; $display("FAIL exec3_high_width got %0d..%0d want %0d", hi_min, hi_max, D); end
    checks++;
    if (lo_min != D) begin errors++; $display("FAIL exec3_low_width got %0d want %0d", lo_min, D); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL exec3_se_tm got %0d bad cycles want 0", viol); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL exec3_done_pulse got %b want 0", done); end
  endtask

  task automatic test_shift();
    int lat, viol, sh;
    run_shift(4, 8'b0000_1101, 4'b1001, 0, lat, viol, sh);
    checks++;
    if (lat != 4 * (2 * D + 2) + 2) begin errors++; $display("FAIL shift4_latency got %0d want %0d", lat, 4 * (2 * D + 2) + 2); end
    checks++;
    if (sreg !== 4'b1011) begin errors++; $display("FAIL shift4_chain got %b want %b", sreg, 4'b1011); end
    checks++;
    if (cycles !== CW'(4)) begin errors++; $display("FAIL shift4_cycles got %0d want 4", cycles); end
    checks++;
    if (edges != 4) begin errors++; $display("FAIL shift4_edges got %0d want 4", edges); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL shift4_se_tm got %0d bad cycles want 0", viol); end
  endtask

  task automatic test_shift_stall();
    int lat, viol, sh;
    run_shift(2, 8'b0000_0010, 4'b0110, 10, lat, viol, sh);
    checks++;
    if (sh != 0) begin errors++; $display("FAIL stall_clk_high got %0d cycles want 0", sh); end
    checks++;
    if (edges != 2) begin errors++; $display("FAIL stall_edges got %0d want 2", edges); end
    checks++;
    if (cycles !== CW'(2)) begin errors++; $display("FAIL stall_cycles got %0d want 2", cycles); end
    checks++;
    if (lat < 0) begin errors++; $display("FAIL stall_done got timeout want done"); end
  endtask

  task automatic test_free_pause();
    int lat, viol;
    bit found = 0;
    clear_stats();
    send_cmd(CMD_FREE, 0);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); #1;
      if (edges == 5 && dut_clk == 1'b0) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL free_reach6 got timeout want period 6"); end
    bus.pause_i = 1'b1;
    wait_done(1'b0, lat, viol);
    bus.pause_i = 1'b0;
    checks++;
    if (cycles !== CW'(6)) begin errors++; $display("FAIL free_cycles got %0d want 6", cycles); end
    checks++;
    if (edges != 6) begin errors++; $display("FAIL free_edges got %0d want 6", edges); end
    checks++;
    if (hi_min != D || hi_max != D || lo_min < D) begin
      errors++; $display("FAIL free_widths got hi %0d..%0d lo %0d want %0d", hi_min, hi_max, lo_min, D);
    end
  endtask

  task automatic test_zero();
    int lat, viol;
    logic [1:0] codes[2] = '{CMD_EXEC, CMD_NOP};
    for (int k = 0; k < 2; k++) begin
      clear_stats();
      send_cmd(codes[k], k * 5);
      wait_done(1'b0, lat, viol);
      checks++;
      if (lat != 2) begin errors++; $display("FAIL zero_latency cmd %0d got %0d want 2", codes[k], lat); end
      checks++;
      if (edges != 0) begin errors++; $display("FAIL zero_edges cmd %0d got %0d want 0", codes[k], edges); end
      checks++;
      if (cycles !== '0) begin errors++; $display("FAIL zero_cycles cmd %0d got %0d want 0", codes[k], cycles); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, viol;
    bit found = 0;
    logic [9:0] obs;
    preload_val = 4'b1000; preload_req = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    preload_req = 1'b0;
    bus.sin_bit_i = 1'b1; bus.sin_valid_i = 1'b1;
    send_cmd(CMD_SHIFT, 5);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (dut_clk) begin found = 1; break; end
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    obs = {dut_clk, dut_se, dut_tm, dut_sin, bus.sout_valid_o, bus.sout_bit_o,
           bus.sin_ready_o, done, busy, bus.cmd_ready_o};
    checks++;
    if (!found || obs !== 10'b0000000001) begin errors++; $display("FAIL midreset_outputs got %b want %b", obs, 10'b0000000001); end
    checks++;
    if (cycles !== '0) begin errors++; $display("FAIL midreset_cycles got %0d want 0", cycles); end
    rst = 1'b0; bus.sin_valid_i = 1'b0;
    clear_stats();
    send_cmd(CMD_EXEC, 1);
    wait_done(1'b0, lat, viol);
    checks++;
    if (lat != 2 * D + 2) begin errors++; $display("FAIL after_reset_latency got %0d want %0d", lat, 2 * D + 2); end
    checks++;
    if (cycles !== CW'(1) || edges != 1) begin errors++; $display("FAIL after_reset_run got %0d/%0d want 1/1", cycles, edges); end
  endtask

  initial begin
    bus.cmd_i = '0; bus.cmd_valid_i = 1'b0; bus.count_i = '0; bus.pause_i = 1'b0;
    bus.sin_valid_i = 1'b0; bus.sin_bit_i = 1'b0; bus.sout_ready_i = 1'b1;
    test_reset();
    test_exec();
    test_shift();
    test_shift_stall();
    test_free_pause();
    test_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
